// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, two-byte assembly and IF/ID register
module fetch_stage #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en_i,
    input  logic              if_id_en_i,
    input  logic              flush_i,
    input  logic              bt_i,
    input  logic [ADDR_W-1:0] bt_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] if_id_instr_o,
    output logic [DATA_W-1:0] if_id_imm_o,
    output logic [ADDR_W-1:0] if_id_pc_next_o,
    output logic              if_id_valid_o
);

    typedef enum logic {ST_OP = 1'b0, ST_IMM = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] op_hold_q, op_hold_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              valid_q, valid_d;

    logic              advance;
    logic              two_byte;
    logic [ADDR_W-1:0] pc_inc;

    // A flush with IF/ID enabled turns the fetch slot into a bubble, so the PC must not move either.
    assign advance  = pc_en_i & if_id_en_i & ~flush_i;
    assign two_byte = (imem_data_i[7:4] == 4'hC);
    assign pc_inc   = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OP;
            pc_q      <= RESET_PC;
            op_hold_q <= '0;
            instr_q   <= '0;
            imm_q     <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_hold_q <= op_hold_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_hold_d = op_hold_q;
        if (bt_i) begin
            state_d   = ST_OP;
            pc_d      = bt_target_i;
            op_hold_d = '0;
        end else if (advance) begin
            pc_d = pc_inc;
            if (state_q == ST_OP) begin
                if (two_byte) begin
                    op_hold_d = imem_data_i;
                    state_d   = ST_IMM;
                end
            end else begin
                state_d = ST_OP;
            end
        end
    end

    always_comb begin
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        if (bt_i || (if_id_en_i && !advance) ||
            (advance && state_q == ST_OP && two_byte)) begin
            instr_d   = '0;
            imm_d     = '0;
            pc_next_d = '0;
            valid_d   = 1'b0;
        end else if (advance) begin
            pc_next_d = pc_inc;
            valid_d   = 1'b1;
            if (state_q == ST_OP) begin
                instr_d = imem_data_i;
                imm_d   = '0;
            end else begin
                instr_d = op_hold_q;
                imm_d   = imem_data_i;
            end
        end
    end

    assign imem_addr_o     = pc_q;
    assign if_id_instr_o   = instr_q;
    assign if_id_imm_o     = imm_q;
    assign if_id_pc_next_o = pc_next_q;
    assign if_id_valid_o   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic       clk;
    logic       rst;
    logic       pc_en, if_id_en, flush, bt;
    logic [7:0] bt_target;
    logic [7:0] imem_addr, imem_data;
    logic [7:0] instr, imm, pc_next;
    logic       valid;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    assign imem_data = mem[imem_addr];

    fetch_stage #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_en_i         (pc_en),
        .if_id_en_i      (if_id_en),
        .flush_i         (flush),
        .bt_i            (bt),
        .bt_target_i     (bt_target),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .if_id_instr_o   (instr),
        .if_id_imm_o     (imm),
        .if_id_pc_next_o (pc_next),
        .if_id_valid_o   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [7:0] e_instr, input logic [7:0] e_imm,
                              input logic [7:0] e_pcn, input logic e_valid, input logic [7:0] e_addr);
        check({tag, ".instr"}, 32'(instr), 32'(e_instr));
        check({tag, ".imm"}, 32'(imm), 32'(e_imm));
        check({tag, ".pc_next"}, 32'(pc_next), 32'(e_pcn));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".addr"}, 32'(imem_addr), 32'(e_addr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'hC4; mem[8'h03] = 8'h5A;
        mem[8'h04] = 8'h33; mem[8'h05] = 8'h44; mem[8'h06] = 8'hC7; mem[8'h07] = 8'h99;
        mem[8'h40] = 8'h55; mem[8'hFE] = 8'h66; mem[8'hFF] = 8'h77;

        rst = 1'b1; pc_en = 1'b0; if_id_en = 1'b0; flush = 1'b0; bt = 1'b0; bt_target = 8'h00;
        step();
        check_ifid("reset", 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);

        rst = 1'b0; pc_en = 1'b1; if_id_en = 1'b1;
        step(); check_ifid("one_byte_a", 8'h11, 8'h00, 8'h01, 1'b1, 8'h01);
        step(); check_ifid("one_byte_b", 8'h22, 8'h00, 8'h02, 1'b1, 8'h02);
        step(); check_ifid("two_byte_bubble", 8'h00, 8'h00, 8'h00, 1'b0, 8'h03);
        step(); check_ifid("two_byte", 8'hC4, 8'h5A, 8'h04, 1'b1, 8'h04);
        step(); check_ifid("after_two_byte", 8'h33, 8'h00, 8'h05, 1'b1, 8'h05);

        pc_en = 1'b0; if_id_en = 1'b0; flush = 1'b1;
        step(); check_ifid("load_use_hold", 8'h33, 8'h00, 8'h05, 1'b1, 8'h05);
        pc_en = 1'b1; if_id_en = 1'b1; flush = 1'b0;
        step(); check_ifid("resume", 8'h44, 8'h00, 8'h06, 1'b1, 8'h06);

        pc_en = 1'b0;
        step(); check_ifid("pc_stall_bubble", 8'h00, 8'h00, 8'h00, 1'b0, 8'h06);
        pc_en = 1'b1; flush = 1'b1;
        step(); check_ifid("flush_bubble", 8'h00, 8'h00, 8'h00, 1'b0, 8'h06);
        flush = 1'b0;

        step(); check_ifid("enter_imm", 8'h00, 8'h00, 8'h00, 1'b0, 8'h07);
        bt = 1'b1; bt_target = 8'h40;
        step(); check_ifid("bt_in_imm", 8'h00, 8'h00, 8'h00, 1'b0, 8'h40);
        bt = 1'b0;
        step(); check_ifid("bt_target_fetch", 8'h55, 8'h00, 8'h41, 1'b1, 8'h41);

        pc_en = 1'b0; if_id_en = 1'b0; bt = 1'b1; bt_target = 8'hFE;
        step(); check_ifid("bt_over_stall", 8'h00, 8'h00, 8'h00, 1'b0, 8'hFE);
        pc_en = 1'b1; if_id_en = 1'b1; bt = 1'b0;
        step(); check_ifid("at_fe", 8'h66, 8'h00, 8'hFF, 1'b1, 8'hFF);
        step(); check_ifid("wrap", 8'h77, 8'h00, 8'h00, 1'b1, 8'h00);

        bt = 1'b1; bt_target = 8'h02;
        step(); check("jump_02.addr", 32'(imem_addr), 32'h02);
        bt = 1'b0;
        step(); check("mid_imm.addr", 32'(imem_addr), 32'h03);
        #2 rst = 1'b1;
        #1 check("async_rst.addr", 32'(imem_addr), 32'h00);
        check("async_rst.valid", 32'(valid), 32'h0);
        #1 rst = 1'b0;
        step(); check_ifid("post_rst_op", 8'h11, 8'h00, 8'h01, 1'b1, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
